// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer, instruction memory, the ALU flag and the program counter.
// Handshake: MEM_REQ stays high while an instruction is wanted; a word transfers on each rising edge where MEM_REQ && MEM_RDY, and MEM_RDY is ignored otherwise.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] INSTR;
  logic               MEM_RDY;
  logic               ZERO;
  logic [ADDR_W-1:0]  PC_COUNT;
  logic               MEM_REQ;
  logic               IR_LOAD;
  logic               EXE_STB;
  logic               PC_ENA;
  logic               PC_LOAD;
  logic [ADDR_W-1:0]  PC_DATA;
  logic               HALTED;
  logic               STACK_ERR;

  modport master (
    input  INSTR, MEM_RDY, ZERO, PC_COUNT,
    output MEM_REQ, IR_LOAD, EXE_STB, PC_ENA, PC_LOAD, PC_DATA, HALTED, STACK_ERR
  );

  modport slave (
    output INSTR, MEM_RDY, ZERO, PC_COUNT,
    input  MEM_REQ, IR_LOAD, EXE_STB, PC_ENA, PC_LOAD, PC_DATA, HALTED, STACK_ERR
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH -> DECODE -> EXEC -> UPDATE per instruction, HALT on HLT.
// Optional CALL/RET return stack is built when PC_CALL_STACK_EN is defined.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int OPC_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  pc_sequencer_if.master bus,
  output logic [2:0]     dbg_state
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'hC);
  localparam logic [OPC_W-1:0] OP_BZ  = OPC_W'(4'hD);
  localparam logic [OPC_W-1:0] OP_BNZ = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               stack_err_q, stack_err_d;
  logic               mem_req_q, exe_stb_q, pc_ena_q, halted_q;
  logic [OPC_W-1:0]   opc;
  logic [ADDR_W-1:0]  target;
  logic               is_jmp, is_bz, is_bnz;
  logic               fetch_go, take_load, stack_fault;
  logic [ADDR_W-1:0]  load_value;
  logic               unused_ir_bits;

  assign opc            = ir_q[INSTR_W-1 -: OPC_W];
  assign target         = ir_q[ADDR_W-1:0];
  assign is_jmp         = (opc == OP_JMP);
  assign is_bz          = (opc == OP_BZ);
  assign is_bnz         = (opc == OP_BNZ);
  assign unused_ir_bits = ^ir_q[INSTR_W-OPC_W-1:ADDR_W];
  assign fetch_go       = (state_q == S_FETCH) && mem_req_q && bus.MEM_RDY;

`ifdef PC_CALL_STACK_EN
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(4'hB);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  top_idx, push_idx;
  logic              is_call, is_ret, stack_full, stack_empty;

  assign is_call     = (opc == OP_CALL);
  assign is_ret      = (opc == OP_RET);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign top_idx     = IDX_W'(sp_q - 1'b1);
  assign push_idx    = IDX_W'(sp_q);
  // Fault depends only on IR and pointer, so it is known before UPDATE and can suppress PC_ENA.
  assign stack_fault = (is_call && stack_full) || (is_ret && stack_empty);
  assign take_load   = is_jmp | (is_bz & bus.ZERO) | (is_bnz & ~bus.ZERO) | is_call | is_ret;
  assign load_value  = is_ret ? stack_q[top_idx] : target;

  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    if (state_q == S_UPDATE && !stack_fault) begin
      if (is_call) begin
        stack_d[push_idx] = bus.PC_COUNT + 1'b1;
        sp_d              = sp_q + 1'b1;
      end else if (is_ret) begin
        sp_d = sp_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end
`else
  logic unused_pc_count;

  assign unused_pc_count = ^bus.PC_COUNT;
  assign stack_fault     = 1'b0;
  assign take_load       = is_jmp | (is_bz & bus.ZERO) | (is_bnz & ~bus.ZERO);
  assign load_value      = target;
`endif

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    stack_err_d = stack_err_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          ir_d    = bus.INSTR;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (opc == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_UPDATE;
      S_UPDATE: begin
        if (stack_fault) begin
          stack_err_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes are registered from the next state so they are clean and all zero in reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      stack_err_q <= 1'b0;
      mem_req_q   <= 1'b0;
      exe_stb_q   <= 1'b0;
      pc_ena_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      stack_err_q <= stack_err_d;
      mem_req_q   <= (state_d == S_FETCH);
      exe_stb_q   <= (state_d == S_EXEC);
      pc_ena_q    <= (state_d == S_UPDATE) && !stack_fault;
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign bus.MEM_REQ   = mem_req_q;
  assign bus.IR_LOAD   = fetch_go;
  assign bus.EXE_STB   = exe_stb_q;
  assign bus.PC_ENA    = pc_ena_q;
  assign bus.PC_LOAD   = pc_ena_q & take_load;
  assign bus.PC_DATA   = (pc_ena_q & take_load) ? load_value : '0;
  assign bus.HALTED    = halted_q;
  assign bus.STACK_ERR = stack_err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch timing, jump/branch decode, memory wait, halt and reset abort.
module tb_pc_sequencer;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] dbg_state;
  int         n_cmp  = 0;
  int         n_fail = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.INSTR    = '0;
    bus.MEM_RDY  = 1'b0;
    bus.ZERO     = 1'b0;
    bus.PC_COUNT = 8'h10;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    bus.MEM_RDY = 1'b0;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  // Waits (bounded) for MEM_REQ, hands over one word, and stops in the UPDATE cycle.
  task automatic issue(input logic [15:0] instr, input logic zero);
    int k = 0;
    while (bus.MEM_REQ !== 1'b1 && k < 16) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.MEM_REQ !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_wait_req: got %b want 1 for instr %h", bus.MEM_REQ, instr);
    end
    bus.INSTR   = instr;
    bus.MEM_RDY = 1'b1;
    bus.ZERO    = zero;
    step();
    bus.MEM_RDY = 1'b0;
    bus.INSTR   = 16'h0000;
    step();
    step();
  endtask

  task automatic test_reset();
    drive_idle();
    bus.MEM_RDY = 1'b1;
    RST = 1'b1;
    step();
    n_cmp++; if ({bus.MEM_REQ, bus.IR_LOAD, bus.EXE_STB, bus.PC_ENA, bus.PC_LOAD, bus.HALTED, bus.STACK_ERR} !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000000", {bus.MEM_REQ, bus.IR_LOAD, bus.EXE_STB, bus.PC_ENA, bus.PC_LOAD, bus.HALTED, bus.STACK_ERR}); end
    n_cmp++; if (bus.PC_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_pc_data: got %h want 00", bus.PC_DATA); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    bus.MEM_RDY = 1'b0;
    RST = 1'b0;
    step();
    n_cmp++; if (bus.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b want 1", bus.MEM_REQ); end
  endtask

  task automatic test_sequential();
    bus.INSTR   = 16'h1234;
    bus.MEM_RDY = 1'b1;
    #1;
    n_cmp++; if (bus.IR_LOAD !== 1'b1) begin n_fail++; $display("FAIL seq_c0_ir_load: got %b want 1", bus.IR_LOAD); end
    step();
    bus.MEM_RDY = 1'b0;
    #1;
    n_cmp++; if ({bus.IR_LOAD, bus.EXE_STB, bus.PC_ENA, bus.MEM_REQ} !== 4'b0000) begin n_fail++; $display("FAIL seq_c1_quiet: got %b want 0000", {bus.IR_LOAD, bus.EXE_STB, bus.PC_ENA, bus.MEM_REQ}); end
    step();
    n_cmp++; if ({bus.EXE_STB, bus.PC_ENA} !== 2'b10) begin n_fail++; $display("FAIL seq_c2_exe: got %b want 10", {bus.EXE_STB, bus.PC_ENA}); end
    step();
    n_cmp++; if ({bus.EXE_STB, bus.PC_ENA, bus.PC_LOAD} !== 3'b010) begin n_fail++; $display("FAIL seq_c3_update: got %b want 010", {bus.EXE_STB, bus.PC_ENA, bus.PC_LOAD}); end
    step();
    n_cmp++; if ({bus.MEM_REQ, bus.PC_ENA} !== 2'b10) begin n_fail++; $display("FAIL seq_c4_refetch: got %b want 10", {bus.MEM_REQ, bus.PC_ENA}); end
  endtask

  task automatic test_jmp();
    issue(16'hC05A, 1'b0);
    n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD} !== 2'b11) begin n_fail++; $display("FAIL jmp_ena_load: got %b want 11", {bus.PC_ENA, bus.PC_LOAD}); end
    n_cmp++; if (bus.PC_DATA !== 8'h5A) begin n_fail++; $display("FAIL jmp_data: got %h want 5a", bus.PC_DATA); end
    step();
    n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD, bus.MEM_REQ} !== 3'b001 || bus.PC_DATA !== 8'h00) begin n_fail++; $display("FAIL jmp_after: got %b/%h want 001/00", {bus.PC_ENA, bus.PC_LOAD, bus.MEM_REQ}, bus.PC_DATA); end
  endtask

  task automatic test_branch();
    logic [15:0] v_instr [5] = '{16'hD020, 16'hD020, 16'hE020, 16'hE020, 16'h7020};
    logic        v_zero  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        v_load  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(v_instr[i], v_zero[i]);
      n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD} !== {1'b1, v_load[i]}) begin n_fail++; $display("FAIL branch_%0d_load: got %b want %b", i, {bus.PC_ENA, bus.PC_LOAD}, {1'b1, v_load[i]}); end
      if (v_load[i]) begin
        n_cmp++; if (bus.PC_DATA !== 8'h20) begin n_fail++; $display("FAIL branch_%0d_data: got %h want 20", i, bus.PC_DATA); end
      end
      step();
    end
    // ZERO is only meaningful in UPDATE: flip it there and the load must follow.
    issue(16'hD033, 1'b0);
    bus.ZERO = 1'b1;
    #1;
    n_cmp++; if ({bus.PC_LOAD, bus.PC_DATA} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL branch_late_zero: got %b/%h want 1/33", bus.PC_LOAD, bus.PC_DATA); end
    step();
    bus.ZERO = 1'b0;
  endtask

  task automatic test_mem_wait();
    bus.INSTR   = 16'hC0FF;
    bus.MEM_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bus.MEM_REQ, bus.IR_LOAD, bus.PC_ENA} !== 3'b100 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL wait_%0d: got %b st=%0d want 100 st=0", i, {bus.MEM_REQ, bus.IR_LOAD, bus.PC_ENA}, dbg_state); end
      step();
    end
    issue(16'h1000, 1'b0);
    n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD} !== 2'b10) begin n_fail++; $display("FAIL wait_done: got %b want 10", {bus.PC_ENA, bus.PC_LOAD}); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.INSTR   = 16'hC011;
    bus.MEM_RDY = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if ({bus.IR_LOAD, bus.EXE_STB, bus.PC_ENA} !== {(i % 4 == 0), (i % 4 == 2), (i % 4 == 3)}) begin n_fail++; $display("FAIL b2b_c%0d: got %b want %b", i, {bus.IR_LOAD, bus.EXE_STB, bus.PC_ENA}, {(i % 4 == 0), (i % 4 == 2), (i % 4 == 3)}); end
      step();
    end
    bus.MEM_RDY = 1'b0;
  endtask

  task automatic test_call_ret();
`ifdef PC_CALL_STACK_EN
    bus.PC_COUNT = 8'h10;
    issue(16'hA040, 1'b0);
    n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD, bus.PC_DATA} !== {2'b11, 8'h40}) begin n_fail++; $display("FAIL call_data: got %b/%h want 11/40", {bus.PC_ENA, bus.PC_LOAD}, bus.PC_DATA); end
    step();
    issue(16'hB000, 1'b0);
    n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD, bus.PC_DATA} !== {2'b11, 8'h11}) begin n_fail++; $display("FAIL ret_data: got %b/%h want 11/11", {bus.PC_ENA, bus.PC_LOAD}, bus.PC_DATA); end
    step();
    for (int i = 0; i < 5; i++) begin
      issue(16'hA050, 1'b0);
      n_cmp++; if (bus.PC_ENA !== (i < 4)) begin n_fail++; $display("FAIL call_nest_%0d_ena: got %b want %b", i, bus.PC_ENA, (i < 4)); end
      step();
    end
    n_cmp++; if ({bus.STACK_ERR, bus.HALTED} !== 2'b11) begin n_fail++; $display("FAIL call_overflow: got %b want 11", {bus.STACK_ERR, bus.HALTED}); end
    apply_reset();
    n_cmp++; if (bus.STACK_ERR !== 1'b0) begin n_fail++; $display("FAIL stack_err_reset: got %b want 0", bus.STACK_ERR); end
    issue(16'hB000, 1'b0);
    n_cmp++; if (bus.PC_ENA !== 1'b0) begin n_fail++; $display("FAIL ret_empty_ena: got %b want 0", bus.PC_ENA); end
    step();
    n_cmp++; if ({bus.STACK_ERR, bus.HALTED} !== 2'b11) begin n_fail++; $display("FAIL ret_empty_err: got %b want 11", {bus.STACK_ERR, bus.HALTED}); end
    apply_reset();
`else
    for (int i = 0; i < 6; i++) begin
      issue((i % 2 == 0) ? 16'hA040 : 16'hB000, 1'b0);
      n_cmp++; if ({bus.PC_ENA, bus.PC_LOAD, bus.STACK_ERR} !== 3'b100) begin n_fail++; $display("FAIL callret_seq_%0d: got %b want 100", i, {bus.PC_ENA, bus.PC_LOAD, bus.STACK_ERR}); end
      step();
    end
    n_cmp++; if ({bus.HALTED, bus.STACK_ERR} !== 2'b00) begin n_fail++; $display("FAIL callret_no_fault: got %b want 00", {bus.HALTED, bus.STACK_ERR}); end
`endif
  endtask

  task automatic test_halt();
    bus.INSTR   = 16'hF000;
    bus.MEM_RDY = 1'b1;
    step();
    n_cmp++; if (bus.HALTED !== 1'b0) begin n_fail++; $display("FAIL halt_decode: got %b want 0", bus.HALTED); end
    step();
    n_cmp++; if ({bus.HALTED, bus.MEM_REQ, bus.EXE_STB, bus.PC_ENA} !== 4'b1000) begin n_fail++; $display("FAIL halt_enter: got %b want 1000", {bus.HALTED, bus.MEM_REQ, bus.EXE_STB, bus.PC_ENA}); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if ({bus.HALTED, bus.MEM_REQ, bus.IR_LOAD, bus.PC_ENA} !== 4'b1000) begin n_fail++; $display("FAIL halt_hold_%0d: got %b want 1000", i, {bus.HALTED, bus.MEM_REQ, bus.IR_LOAD, bus.PC_ENA}); end
    end
    bus.MEM_RDY = 1'b0;
    RST = 1'b1;
    #1;
    n_cmp++; if (bus.HALTED !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL halt_async_reset: got %b st=%0d want 0 st=0", bus.HALTED, dbg_state); end
    step();
    RST = 1'b0;
    step();
    n_cmp++; if ({bus.MEM_REQ, bus.HALTED} !== 2'b10) begin n_fail++; $display("FAIL halt_restart: got %b want 10", {bus.MEM_REQ, bus.HALTED}); end
  endtask

  task automatic test_reset_mid();
    bus.INSTR   = 16'hC077;
    bus.MEM_RDY = 1'b1;
    step();
    bus.MEM_RDY = 1'b0;
    step();
    n_cmp++; if (bus.EXE_STB !== 1'b1) begin n_fail++; $display("FAIL abort_in_exec: got %b want 1", bus.EXE_STB); end
    RST = 1'b1;
    #1;
    n_cmp++; if ({bus.EXE_STB, bus.PC_ENA, bus.MEM_REQ, bus.PC_DATA} !== 11'b0) begin n_fail++; $display("FAIL abort_outputs: got %b/%h want 000/00", {bus.EXE_STB, bus.PC_ENA, bus.MEM_REQ}, bus.PC_DATA); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (bus.PC_ENA !== 1'b0) begin n_fail++; $display("FAIL abort_hold_%0d: got %b want 0", i, bus.PC_ENA); end
    end
    RST = 1'b0;
    step();
    n_cmp++; if ({bus.MEM_REQ, bus.PC_ENA} !== 2'b10) begin n_fail++; $display("FAIL abort_refetch: got %b want 10", {bus.MEM_REQ, bus.PC_ENA}); end
    issue(16'hC066, 1'b0);
    n_cmp++; if ({bus.PC_LOAD, bus.PC_DATA} !== {1'b1, 8'h66}) begin n_fail++; $display("FAIL abort_next_jmp: got %b/%h want 1/66", bus.PC_LOAD, bus.PC_DATA); end
    step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_sequential();
    test_jmp();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_call_ret();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
